// File: rtl/score_overlay_sched.sv
// Shared glyph-ROM scheduler for N fixed-size text overlays.
// Per-overlay hit/offset logic is replicated; a fixed-priority arbiter drives the ROM address.

module score_overlay_hit #(
    parameter int REGION_W = 120,
    parameter int REGION_H = 48,
    parameter int ADDR_W   = 15
) (
    input  logic [9:0]        px,
    input  logic [9:0]        py,
    input  logic [9:0]        rx,
    input  logic [9:0]        ry,
    input  logic              en,
    input  logic              blink,
    input  logic              phase,
    output logic              hit,
    output logic [ADDR_W-1:0] off
);
    localparam logic [10:0]       W_M1 = 11'(REGION_W - 1);
    localparam logic [10:0]       H_M1 = 11'(REGION_H - 1);
    localparam logic [ADDR_W-1:0] W_A  = ADDR_W'(REGION_W);

    logic [10:0] x_hi, y_hi;
    logic [9:0]  dx, dy;
    logic        in_x, in_y;

    // 11-bit upper bounds keep overlays near 1023 from wrapping to column 0
    assign x_hi = {1'b0, rx} + W_M1;
    assign y_hi = {1'b0, ry} + H_M1;
    assign in_x = (px >= rx) && ({1'b0, px} <= x_hi);
    assign in_y = (py >= ry) && ({1'b0, py} <= y_hi);
    assign hit  = en && !(blink && phase) && in_x && in_y;

    assign dx  = px - rx;
    assign dy  = py - ry;
    assign off = ADDR_W'(dx) + ADDR_W'(dy) * W_A;
endmodule

module score_overlay_sched #(
    parameter int N_REGION     = 3,
    parameter int REGION_W     = 120,
    parameter int REGION_H     = 48,
    parameter int ADDR_W       = 15,
    parameter int BLINK_FRAMES = 30
) (
    input  logic                  iVGA_CLK,
    input  logic                  iRST_n,
    input  logic [9:0]            iVGA_X,
    input  logic [9:0]            iVGA_Y,
    input  logic                  iFRAME_START,
    input  logic [N_REGION-1:0]   iREGION_EN,
    input  logic [10*N_REGION-1:0] iREGION_X,
    input  logic [10*N_REGION-1:0] iREGION_Y,
    input  logic [3*N_REGION-1:0] iREGION_RGB,
    input  logic [N_REGION-1:0]   iBLINK,
    output logic [ADDR_W-1:0]     oROM_ADDR,
    input  logic                  iROM_Q,
    output logic [2:0]            oRGB,
    output logic                  oVALID
);
    localparam int FC_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [FC_W-1:0] FC_LAST = FC_W'(BLINK_FRAMES - 1);

    logic [N_REGION-1:0]             sh_en, sh_blink;
    logic [N_REGION-1:0][9:0]        sh_x, sh_y;
    logic [N_REGION-1:0][2:0]        sh_rgb;
    logic [FC_W-1:0]                 frame_cnt;
    logic                            blink_phase;

    logic [N_REGION-1:0]             hit;
    logic [N_REGION-1:0][ADDR_W-1:0] off;

    logic                            win_hit;
    logic [ADDR_W-1:0]               win_addr;
    logic [2:0]                      win_rgb;

    logic [1:0]                      vld_pipe;
    logic [1:0][2:0]                 rgb_pipe;

    // Shadow config and blink phase only move at frame boundaries
    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            sh_en       <= '0;
            sh_blink    <= '0;
            sh_x        <= '0;
            sh_y        <= '0;
            sh_rgb      <= '0;
            frame_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (iFRAME_START) begin
            sh_en    <= iREGION_EN;
            sh_blink <= iBLINK;
            sh_x     <= iREGION_X;
            sh_y     <= iREGION_Y;
            sh_rgb   <= iREGION_RGB;
            if (frame_cnt == FC_LAST) begin
                frame_cnt   <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                frame_cnt <= frame_cnt + 1'b1;
            end
        end
    end

    for (genvar k = 0; k < N_REGION; k++) begin : g_region
        score_overlay_hit #(
            .REGION_W(REGION_W),
            .REGION_H(REGION_H),
            .ADDR_W  (ADDR_W)
        ) u_hit (
            .px   (iVGA_X),
            .py   (iVGA_Y),
            .rx   (sh_x[k]),
            .ry   (sh_y[k]),
            .en   (sh_en[k]),
            .blink(sh_blink[k]),
            .phase(blink_phase),
            .hit  (hit[k]),
            .off  (off[k])
        );
    end

    // Scan high-to-low so the lowest hit index is the final assignment
    always_comb begin
        win_hit  = 1'b0;
        win_addr = '0;
        win_rgb  = 3'b000;
        for (int k = N_REGION - 1; k >= 0; k--) begin
            if (hit[k]) begin
                win_hit  = 1'b1;
                win_addr = ADDR_W'(k * REGION_W * REGION_H) + off[k];
                win_rgb  = sh_rgb[k];
            end
        end
    end

    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            oROM_ADDR <= '0;
            vld_pipe  <= '0;
            rgb_pipe  <= '0;
            oVALID    <= 1'b0;
            oRGB      <= 3'b000;
        end else begin
            oROM_ADDR   <= win_addr;
            vld_pipe[0] <= win_hit;
            rgb_pipe[0] <= win_rgb;
            vld_pipe[1] <= vld_pipe[0];
            rgb_pipe[1] <= rgb_pipe[0];
            oVALID      <= vld_pipe[1] & iROM_Q;
            oRGB        <= (vld_pipe[1] & iROM_Q) ? rgb_pipe[1] : 3'b000;
        end
    end
endmodule
